dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder (slave) for the three-stage RV32I core.
- Receives the load/store requests the execute stage issues: address, byte strobes, replicated store data, and funct3.
- Performs the access on an internal word-organised SRAM model with configurable wait states.
- Returns naturally-extended load data or a store acknowledgement over a valid/ready response channel.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; legal byte addresses are 0 .. DEPTH_WORDS*4-1
WAIT_CYCLES, 0, extra cycles inserted between request acceptance and memory access (0..15)

Ports:
clk  input  1  clock, rising edge
resetb  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request (registered)
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wstrb  input  4  byte-lane write enables (store only)
req_wdata  input  32  store data, already lane-replicated by the requester
req_funct3  input  3  load type: LB=000 LH=001 LW=010 LBU=100 LHU=101
rsp_valid  output  1  response valid (registered)
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  access fault (range, misalignment, or illegal funct3)

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - State=IDLE, wait counter=0.
  - Memory array is not reset.
- First rising edge after resetb deasserts: req_ready -> 1.
- FSM states: IDLE, WAIT, RESP.
- IDLE (req_ready=1):
  - On req_valid at a clock edge, capture we/addr/wstrb/wdata/funct3 and drop req_ready to 0.
  - WAIT_CYCLES=0: perform the access on that same edge and go to RESP.
  - Otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the edge where the counter is 0, perform the access and go to RESP.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err stable until rsp_ready is sampled high.
  - On that edge: rsp_valid -> 0, req_ready -> 1, go to IDLE.
  - The earliest next acceptance is the following edge, so there is one bubble between transactions.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the acceptance edge.
- Word index is addr[31:2], taken modulo nothing; any addr >= DEPTH_WORDS*4 is a range error.
- Store:
  - Write each lane i where wstrb[i]=1 with wdata[8i+7:8i].
  - wstrb=0 is a legal no-op with rsp_err=0.
  - rsp_rdata=0.
- Load formatting (addr[1:0] selects the lane):
  - LB/LBU: take byte at lane addr[1:0], sign- or zero-extend.
  - LH/LHU: take halfword at addr[1]?[31:16]:[15:0]; fault if addr[0]=1.
  - LW: take the whole word; fault if addr[1:0]!=0.
  - funct3 011/110/111 on a load: fault.
- Any fault (load or store):
  - No memory write.
  - rsp_err=1, rsp_rdata=0.
  - The transaction still completes normally through RESP.
- Read-after-write: a load accepted after a store's response has completed returns the stored data. The FSM serialises transactions, so there is no hazard path.
- Reset asserted mid-transaction:
  - Immediately return to IDLE with all outputs at reset values.
  - If the access edge has not yet occurred, the pending store is not performed.
- req_valid while req_ready=0: ignored; the requester must hold it.

Decomposition:
- Shared package `dmem_pkg`:
  - Load funct3 constants OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU.
  - Store constants OP_SB, OP_SH, OP_SW, so the execute stage shares the same names.
  - FSM state encoding.
- Sub-module `load_align`: purely combinational. Inputs are the word, addr[1:0] and funct3; outputs are the extended data and a misalign/illegal flag. It is reused by the writeback stage for a future cache path.

Test Plan:
- WAIT_CYCLES=0; store addr=0x10, wstrb=1111, wdata=0xDEADBEEF; then LW 0x10 -> rsp_valid 1 edge after each acceptance; load rdata=0xDEADBEEF, err=0.
- Store SB addr=0x21, wstrb=0010, wdata=0x80808080 over a zeroed word; then LB 0x21 -> rdata=0xFFFFFF80; LBU 0x21 -> 0x00000080; LW 0x20 -> 0x00008000.
- LH 0x23 -> err=1, rdata=0; LW 0x22 -> err=1; funct3=011 -> err=1; store to 0x1000 (DEPTH_WORDS=1024) -> err=1, and a subsequent LW 0x0 is unchanged.
- WAIT_CYCLES=3; hold rsp_ready=0 for 5 cycles -> rsp_valid rises 4 edges after acceptance, data stays stable, req_ready stays 0; release rsp_ready -> req_ready returns 1 on the next edge.
- Store 0x44, wstrb=1111, WAIT_CYCLES=3; pulse resetb low during the 2nd WAIT cycle -> all outputs reset, req_ready=1 after release, and LW 0x44 returns the old value.
- Back-to-back random loads/stores against a scoreboard (2000 transactions, random rsp_ready backpressure) -> all rdata/err match the model, and rsp_valid never rises while req_ready=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory request path: funct3 encodings,
// responder FSM state encoding and the captured-request record.
package dmem_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  localparam logic [2:0] OP_SB  = 3'b000;
  localparam logic [2:0] OP_SH  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } dmem_req_t;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the byte/halfword/word addressed by
// addr_lo, extends it per funct3 and flags misalignment or illegal funct3.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        fault
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
    lane_half = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // A faulting access always returns zero data.
  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      OP_LB:  data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU: data = {24'd0, lane_byte};
      OP_LH: begin
        if (addr_lo[0]) fault = 1'b1;
        else            data  = {{16{lane_half[15]}}, lane_half};
      end
      OP_LHU: begin
        if (addr_lo[0]) fault = 1'b1;
        else            data  = {16'd0, lane_half};
      end
      OP_LW: begin
        if (addr_lo != 2'd0) fault = 1'b1;
        else                 data  = word;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the RV32I core: accepts one request at a time,
// performs it on a word SRAM after WAIT_CYCLES, and returns a response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  dmem_req_t   cap_q, cap_d;
  dmem_req_t   req_in;

  logic        access;
  logic        acc_we;
  logic [29:0] acc_word;
  logic [3:0]  acc_wstrb;
  logic [31:0] acc_wdata;
  logic        acc_range_err;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word_q;

  logic [31:0] align_data;
  logic        align_fault;
  logic        cap_range_err;
  logic        rsp_fault;

  always_comb begin
    req_in.we     = req_we;
    req_in.addr   = req_addr;
    req_in.wstrb  = req_wstrb;
    req_in.wdata  = req_wdata;
    req_in.funct3 = req_funct3;
  end

  // With zero wait states the access happens on the acceptance edge, so the
  // live request is used; otherwise the captured copy is.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_word  = req_addr[31:2];
      acc_wstrb = req_wstrb;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = cap_q.we;
      acc_word  = cap_q.addr[31:2];
      acc_wstrb = cap_q.wstrb;
      acc_wdata = cap_q.wdata;
    end
    acc_range_err = ({2'b00, acc_word} >= 32'(DEPTH_WORDS));
    acc_idx       = acc_word[AW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    cap_d       = cap_q;
    access      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          cap_d       = req_in;
          req_ready_d = 1'b0;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // rsp_valid rises one edge after entering RESP, giving the
        // registered SRAM read a cycle to settle into the formatter.
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      cap_q       <= cap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (access) begin
      if (acc_we && !acc_range_err) begin
        for (int i = 0; i < 4; i++) begin
          if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
      rd_word_q <= mem[acc_idx];
    end
  end

  load_align u_load_align (
    .word    (rd_word_q),
    .addr_lo (cap_q.addr[1:0]),
    .funct3  (cap_q.funct3),
    .data    (align_data),
    .fault   (align_fault)
  );

  // Stores ignore funct3 and alignment; only the range check applies.
  assign cap_range_err = ({2'b00, cap_q.addr[31:2]} >= 32'(DEPTH_WORDS));
  assign rsp_fault     = cap_range_err | (!cap_q.we & align_fault);

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q & rsp_fault;
  assign rsp_rdata = (rsp_valid_q && !cap_q.we && !rsp_fault) ? align_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states), a directed
// vector table, reset/backpressure sequences and a random scoreboard run.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk;
  logic        resetb0, resetb1;
  logic        req_valid0, req_valid1;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_ready;
  logic        rr0, rv0, re0, rr1, rv1, re1;
  logic [31:0] rd0, rd1;

  logic        sel;
  logic        cur_rr, cur_rv, cur_re;
  logic [31:0] cur_rd;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int txn_no = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs[24];

  logic [31:0] model [2][1024];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .resetb(resetb0), .req_valid(req_valid0), .req_ready(rr0),
    .req_we(req_we), .req_addr(req_addr), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata), .req_funct3(req_funct3), .rsp_valid(rv0),
    .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(re0)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .resetb(resetb1), .req_valid(req_valid1), .req_ready(rr1),
    .req_we(req_we), .req_addr(req_addr), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata), .req_funct3(req_funct3), .rsp_valid(rv1),
    .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(re1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cur_rr = sel ? rr1 : rr0;
    cur_rv = sel ? rv1 : rv0;
    cur_rd = sel ? rd1 : rd0;
    cur_re = sel ? re1 : re0;
  end

  always @(negedge clk) begin
    if (rv0 && rr0) overlap++;
    if (rv1 && rr1) overlap++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_load(input int s, input logic [31:0] a, input logic [2:0] f3,
                                     output logic [31:0] rd, output logic err);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    rd  = 32'd0;
    err = 1'b0;
    if (a >= 32'd4096) begin
      err = 1'b1;
      return;
    end
    w = model[s][a[11:2]];
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000: rd = {{24{b[7]}}, b};
      3'b100: rd = {24'd0, b};
      3'b001: if (a[0]) err = 1'b1; else rd = {{16{h[15]}}, h};
      3'b101: if (a[0]) err = 1'b1; else rd = {16'd0, h};
      3'b010: if (a[1:0] != 2'd0) err = 1'b1; else rd = w;
      default: err = 1'b1;
    endcase
  endfunction

  // Starts and ends just after a falling edge.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int hold, input string tag);
    exp_t e;
    exp_t got_e;
    int   n;
    int   lat;
    logic got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    lat     = sel ? 4 : 1;
    n = 0;
    while (!cur_rr && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!cur_rr) begin
      check("req_ready_timeout", {31'd0, cur_rr}, 32'd1);
      return;
    end
    req_we     = we;
    req_addr   = addr;
    req_wstrb  = wstrb;
    req_wdata  = wdata;
    req_funct3 = f3;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    got = 1'b0;
    for (n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (cur_rv) begin
        got = 1'b1;
        break;
      end
      check("req_ready_low_while_busy", {31'd0, cur_rr}, 32'd0);
      @(posedge clk);
    end
    got_e = sbq.pop_front();
    if (!got) begin
      check("rsp_valid_timeout", {31'd0, cur_rv}, 32'd1);
      return;
    end
    check("latency", n, lat);
    check({tag, "_rdata"}, cur_rd, got_e.rdata);
    check({tag, "_err"}, {31'd0, cur_re}, {31'd0, got_e.err});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, cur_rv}, 32'd1);
      check("hold_rdata_stable", cur_rd, got_e.rdata);
      check("hold_err_stable", {31'd0, cur_re}, {31'd0, got_e.err});
      check("hold_req_ready_low", {31'd0, cur_rr}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drops", {31'd0, cur_rv}, 32'd0);
    check("req_ready_returns", {31'd0, cur_rr}, 32'd1);
    if (we && !exp_err) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) model[sel][addr[11:2]][8*i +: 8] = wdata[8*i +: 8];
    end
    $display("txn %0d %s dut_wait%0d we=%0b addr=%h wstrb=%h wdata=%h f3=%0d -> rdata=%h err=%0b lat=%0d",
             txn_no, tag, sel ? 3 : 0, we, addr, wstrb, wdata, f3, cur_rd, got_e.err, n);
    txn_no++;
  endtask

  task automatic init_region();
    for (int w = 64; w < 80; w++)
      do_txn(1'b1, 32'(w * 4), 4'hF, $urandom, OP_SW, 32'd0, 1'b0, 0, "init");
  endtask

  task automatic random_run(input int count);
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] erd;
    logic        eerr;
    for (int t = 0; t < count; t++) begin
      we    = 1'($urandom_range(1));
      addr  = ($urandom_range(15) == 0) ? 32'h1000 + 32'($urandom_range(255))
                                        : 32'h100 + 32'($urandom_range(63));
      wstrb = 4'($urandom_range(15));
      wdata = $urandom;
      f3    = 3'($urandom_range(7));
      if (we) begin
        erd  = 32'd0;
        eerr = (addr >= 32'd4096);
      end else begin
        model_load(int'(sel), addr, f3, erd, eerr);
      end
      do_txn(we, addr, wstrb, wdata, f3, erd, eerr, $urandom_range(3), "rand");
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, OP_SW,  32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,   4'h0, 32'h0,        OP_LW,  32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h12,   4'h0, 32'h0,        OP_LHU, 32'h0000DEAD, 1'b0};
    vecs[3]  = '{1'b0, 32'h10,   4'h0, 32'h0,        OP_LH,  32'hFFFFBEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h13,   4'h0, 32'h0,        OP_LB,  32'hFFFFFFDE, 1'b0};
    vecs[5]  = '{1'b0, 32'h12,   4'h0, 32'h0,        OP_LBU, 32'h000000AD, 1'b0};
    vecs[6]  = '{1'b1, 32'h20,   4'hF, 32'h00000000, OP_SW,  32'h00000000, 1'b0};
    vecs[7]  = '{1'b1, 32'h21,   4'h2, 32'h80808080, OP_SB,  32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 32'h21,   4'h0, 32'h0,        OP_LB,  32'hFFFFFF80, 1'b0};
    vecs[9]  = '{1'b0, 32'h21,   4'h0, 32'h0,        OP_LBU, 32'h00000080, 1'b0};
    vecs[10] = '{1'b0, 32'h20,   4'h0, 32'h0,        OP_LW,  32'h00008000, 1'b0};
    vecs[11] = '{1'b0, 32'h23,   4'h0, 32'h0,        OP_LH,  32'h00000000, 1'b1};
    vecs[12] = '{1'b0, 32'h22,   4'h0, 32'h0,        OP_LW,  32'h00000000, 1'b1};
    vecs[13] = '{1'b0, 32'h20,   4'h0, 32'h0,        3'b011, 32'h00000000, 1'b1};
    vecs[14] = '{1'b1, 32'h0,    4'hF, 32'h12345678, OP_SW,  32'h00000000, 1'b0};
    vecs[15] = '{1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, OP_SW,  32'h00000000, 1'b1};
    vecs[16] = '{1'b0, 32'h0,    4'h0, 32'h0,        OP_LW,  32'h12345678, 1'b0};
    vecs[17] = '{1'b1, 32'h0,    4'h0, 32'hFFFFFFFF, OP_SW,  32'h00000000, 1'b0};
    vecs[18] = '{1'b0, 32'h0,    4'h0, 32'h0,        OP_LW,  32'h12345678, 1'b0};
    vecs[19] = '{1'b1, 32'hFFC,  4'hF, 32'hCAFEF00D, OP_SW,  32'h00000000, 1'b0};
    vecs[20] = '{1'b0, 32'hFFC,  4'h0, 32'h0,        OP_LW,  32'hCAFEF00D, 1'b0};
    vecs[21] = '{1'b0, 32'h1000, 4'h0, 32'h0,        OP_LW,  32'h00000000, 1'b1};
    vecs[22] = '{1'b0, 32'h20,   4'h0, 32'h0,        OP_LH,  32'hFFFF8000, 1'b0};
    vecs[23] = '{1'b0, 32'h20,   4'h0, 32'h0,        3'b111, 32'h00000000, 1'b1};

    sel        = 1'b0;
    resetb0    = 1'b0;
    resetb1    = 1'b0;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wstrb  = 4'd0;
    req_wdata  = 32'd0;
    req_funct3 = 3'd0;
    rsp_ready  = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_req_ready0", {31'd0, rr0}, 32'd0);
    check("reset_rsp_valid0", {31'd0, rv0}, 32'd0);
    check("reset_rsp_rdata0", rd0, 32'd0);
    check("reset_rsp_err0", {31'd0, re0}, 32'd0);
    check("reset_req_ready3", {31'd0, rr1}, 32'd0);
    check("reset_rsp_valid3", {31'd0, rv1}, 32'd0);
    resetb0 = 1'b1;
    resetb1 = 1'b1;
    #1;
    check("req_ready_before_edge", {31'd0, rr0}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("req_ready_after_release0", {31'd0, rr0}, 32'd1);
    check("req_ready_after_release3", {31'd0, rr1}, 32'd1);

    for (int i = 0; i < 24; i++)
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, vecs[i].f3,
             vecs[i].exp_rd, vecs[i].exp_err, 0, $sformatf("vec%0d", i));

    // Wait-state instance: long backpressure, then reset during WAIT.
    sel = 1'b1;
    do_txn(1'b1, 32'h44, 4'hF, 32'h11223344, OP_SW, 32'd0, 1'b0, 5, "w3_store_hold");
    do_txn(1'b0, 32'h44, 4'h0, 32'h0, OP_LW, 32'h11223344, 1'b0, 5, "w3_load_hold");

    req_we     = 1'b1;
    req_addr   = 32'h44;
    req_wstrb  = 4'hF;
    req_wdata  = 32'h55667788;
    req_funct3 = OP_SW;
    req_valid1 = 1'b1;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetb1 = 1'b0;
    #1;
    check("midreset_req_ready", {31'd0, rr1}, 32'd0);
    check("midreset_rsp_valid", {31'd0, rv1}, 32'd0);
    check("midreset_rsp_rdata", rd1, 32'd0);
    check("midreset_rsp_err", {31'd0, re1}, 32'd0);
    repeat (3) @(negedge clk);
    check("midreset_held_rsp_valid", {31'd0, rv1}, 32'd0);
    resetb1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_req_ready_after", {31'd0, rr1}, 32'd1);
    $display("txn %0d midreset_store dut_wait3 we=1 addr=00000044 aborted by reset", txn_no);
    txn_no++;
    do_txn(1'b0, 32'h44, 4'h0, 32'h0, OP_LW, 32'h11223344, 1'b0, 0, "w3_after_reset");

    sel = 1'b0;
    init_region();
    random_run(1000);
    sel = 1'b1;
    init_region();
    random_run(1000);

    check("valid_while_ready_count", overlap, 32'd0);
    check("scoreboard_empty", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
